// File: rtl/lib_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared constants and types for the pixel arbiter tree and its readout
// stages.
//   WIDTH      : event word width produced by pixel_hierarchy.data_out_o
//   TS_WIDTH   : default timestamp width used by event_stream_packer
//   evt_pkt_t  : {timestamp, event} packet as it leaves event_stream_packer
//   fifo_op_e  : push/pop combination seen by evt_sync_fifo in one cycle
// -----------------------------------------------------------------------------
package lib_arbiter_pkg;

  localparam int WIDTH    = 8;
  localparam int TS_WIDTH = 16;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    evt;
  } evt_pkt_t;

  // Bit 1 = push, bit 0 = pop, so {push, pop} casts straight onto this enum.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Builds a packet at the default widths.
  function automatic evt_pkt_t make_evt_pkt(input logic [TS_WIDTH-1:0] ts,
                                            input logic [WIDTH-1:0]    evt);
    evt_pkt_t pkt;
    pkt.ts  = ts;
    pkt.evt = evt;
    return pkt;
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// -----------------------------------------------------------------------------
// evt_sync_fifo
// Single-clock first-word fall-through FIFO. A push is accepted when the FIFO
// is not full, or when it is full and a pop happens in the same cycle.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset; clears pointers and fill,
//                 a push presented in the reset cycle is ignored
//   push_i      : write request
//   push_data_i : write data
//   pop_i       : read request (only effective while valid_o=1)
//   push_ok_o   : the current push request is accepted this cycle
//   head_o      : head entry (don't-care while valid_o=0)
//   valid_o     : FIFO not empty (registered)
//   fill_o      : occupancy (registered)
// -----------------------------------------------------------------------------
module evt_sync_fifo
  import lib_arbiter_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic                       push_ok_o,
  output logic [DATA_W-1:0]          head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [FW-1:0]     fill_r;
  logic [FW-1:0]     fill_nxt_s;
  logic              valid_r;
  logic              full_r;
  logic              pop_s;
  logic              push_s;
  fifo_op_e          op_s;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_s  = valid_r & pop_i & ~reset_i;
  assign push_s = push_i & ~reset_i & (~full_r | pop_s);
  assign op_s   = fifo_op_e'({push_s, pop_s});

  // Next occupancy from the push/pop combination of this cycle.
  always_comb begin
    fill_nxt_s = fill_r;
    case (op_s)
      FIFO_PUSH: fill_nxt_s = fill_r + FW'(1);
      FIFO_POP:  fill_nxt_s = fill_r - FW'(1);
      default:   fill_nxt_s = fill_r;
    endcase
  end

  // Pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {FW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      fill_r  <= fill_nxt_s;
      valid_r <= (fill_nxt_s != FW'(0));
      full_r  <= (fill_nxt_s == FW'(DEPTH));
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  assign push_ok_o = push_s;
  assign head_o    = mem_r[rd_ptr_r];
  assign valid_o   = valid_r;
  assign fill_o    = fill_r;

endmodule

// File: rtl/event_stream_packer.sv
// -----------------------------------------------------------------------------
// event_stream_packer
// Captures pixel_hierarchy event words, tags each with a free-running
// timestamp and buffers the {timestamp, event} packets in a FIFO drained over
// a valid/ready stream. Events arriving while the FIFO is full (and not
// draining in that cycle) are dropped and flagged.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset
//   evt_valid_i : one-cycle event strobe
//   evt_data_i  : event word
//   m_valid_o   : packet available
//   m_ready_i   : consumer accepts packet
//   m_data_o    : packet {timestamp, event}
//   fill_o      : FIFO occupancy
//   overflow_o  : sticky, set on the first dropped event
//   drop_cnt_o  : saturating drop count (only with EVT_DROP_CNT_EN defined)
// Build option: EVT_DROP_CNT_EN adds the drop counter and drop_cnt_o.
// -----------------------------------------------------------------------------
module event_stream_packer #(
  parameter int WIDTH     = lib_arbiter_pkg::WIDTH,
  parameter int TS_WIDTH  = lib_arbiter_pkg::TS_WIDTH,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         evt_valid_i,
  input  logic [WIDTH-1:0]             evt_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [TS_WIDTH+WIDTH-1:0]    m_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o,
  output logic                         overflow_o
`ifdef EVT_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]         drop_cnt_o
`endif
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("event_stream_packer: DEPTH must be a power of two, at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("event_stream_packer: CNT_WIDTH must be at least 1");
  end

  logic [TS_WIDTH-1:0] ts_r;
  logic                push_ok_s;
  logic                drop_s;
  logic                overflow_r;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_r <= {TS_WIDTH{1'b0}};
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1);
    end
  end

  evt_sync_fifo #(
    .DATA_W (TS_WIDTH + WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (evt_valid_i),
    .push_data_i ({ts_r, evt_data_i}),
    .pop_i       (m_ready_i),
    .push_ok_o   (push_ok_s),
    .head_o      (m_data_o),
    .valid_o     (m_valid_o),
    .fill_o      (fill_o)
  );

  // An event is dropped when the FIFO refuses it; events during reset are
  // ignored rather than dropped.
  assign drop_s = evt_valid_i & ~push_ok_s & ~reset_i;

  // Sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow_o = overflow_r;

`ifdef EVT_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  // Saturating drop counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: doc/event_stream_packer.md
# event_stream_packer

Downstream stage of `pixel_hierarchy`. It captures each arbitrated pixel event word (`data_out_o`), tags it with a free-running timestamp, and buffers it in a FIFO. Events leave on a valid/ready stream toward the readout/transport logic. Events that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `WIDTH`, default `lib_arbiter_pkg::WIDTH`: event word width; must match the hierarchy's `data_out_o`.
- `TS_WIDTH`, default 16: timestamp counter width.
- `DEPTH`, default 16: number of FIFO entries; must be a power of two, at least 2.
- `CNT_WIDTH`, default 16: width of the drop counter.

Ports:
- `clk_i`, input, 1: the single clock.
- `reset_i`, input, 1: synchronous, active-high reset.
- `evt_valid_i`, input, 1: one-cycle strobe; `evt_data_i` is valid in the same cycle.
- `evt_data_i`, input, `WIDTH`: event word from `pixel_hierarchy.data_out_o`.
- `m_valid_o`, output, 1: output packet available.
- `m_ready_i`, input, 1: consumer accepts the packet.
- `m_data_o`, output, `TS_WIDTH+WIDTH`: the packet, `{timestamp, event}`.
- `fill_o`, output, `$clog2(DEPTH+1)`: current FIFO occupancy.
- `overflow_o`, output, 1: sticky flag, set on the first dropped event.
- `drop_cnt_o`, output, `CNT_WIDTH`: number of dropped events. Present only with `EVT_DROP_CNT_EN`.

## Operation
- **Timestamp counter `ts`**
  - Increments by 1 every cycle.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- **Capture**
  - When `evt_valid_i`=1, the packet `{ts, evt_data_i}` is formed using the `ts` value of that same cycle.
- **Push rule**
  - Packet is written if `fill_o` < `DEPTH`.
  - Packet is also written if `fill_o` = `DEPTH` and a pop occurs in the same cycle.
  - Otherwise the packet is dropped.
- **Pop**
  - A pop occurs when `m_valid_o` && `m_ready_i`.
- **Occupancy**
  - `fill_o` is updated by +1 on push-only, −1 on pop-only, and is unchanged on push+pop.
- **Ordering**
  - Strict FIFO. Pointers wrap modulo `DEPTH`.
- **Output**
  - First-word fall-through: `m_valid_o` = (`fill_o` ≠ 0).
  - `m_data_o` is the head entry.
  - `m_data_o` is stable while `m_valid_o`=1 and `m_ready_i`=0.
  - `m_data_o` is don't-care while `m_valid_o`=0.
- **Drop handling**
  - On a drop, `overflow_o` is set to 1 and held until reset.
  - The drop counter increments and saturates at 2^CNT_WIDTH−1; it never wraps.
- **Reset** (applied at any time, including mid-operation)
  - Pointers, `fill_o`, `ts`, `overflow_o` and the drop counter are cleared to 0.
  - Any FIFO contents are discarded.
  - An event presented in the reset cycle is ignored.

## Timing
- Reset values: `m_valid_o`=0, `fill_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `ts`=0. `m_data_o` is don't-care.
- Capture latency: an event strobed in cycle N appears with `m_valid_o`=1 in cycle N+1, provided the FIFO was empty.
- Pop timing: the head advances on the edge where `m_valid_o` && `m_ready_i`; the next entry is visible in the following cycle.
- `fill_o`, `overflow_o` and `drop_cnt_o` reflect the edge just taken: they are registered, with no combinational path from inputs.
- Throughput: one event accepted per cycle, one packet emitted per cycle.

## Configuration
- Macro: `EVT_DROP_CNT_EN`.
  - **Defined:** the `drop_cnt_o` port and its saturating `CNT_WIDTH` counter are present.
  - **Undefined:** both the port and the counter are absent.
- `overflow_o` exists in both builds.

## Structure
- Add to `lib_arbiter_pkg`:
  - `TS_WIDTH` constant.
  - `evt_pkt_t`, a packed struct `{logic [TS_WIDTH-1:0] ts; logic [WIDTH-1:0] evt;}`.
- Sub-module: `evt_sync_fifo`.
  - Parameterised by data width and `DEPTH`.
  - Contains the storage, pointers, fill counter and push/pop logic.
- The top level holds the timestamp counter, drop logic and overflow logic.

## Test plan
1. **Reset state:** hold `reset_i` for 2 cycles → `m_valid_o`=0, `fill_o`=0, `overflow_o`=0, `drop_cnt_o`=0.
2. **Single event:** strobe `evt_data_i`=0x2A while `ts`=5, with `m_ready_i`=1 → in the next cycle `m_valid_o`=1 and `m_data_o`={16'd5, 0x2A}; the cycle after that, `m_valid_o`=0.
3. **Overflow:** with `m_ready_i`=0, strobe 17 back-to-back events 0..16 → `fill_o`=16, `overflow_o`=1, `drop_cnt_o`=1. Then raise `m_ready_i` → packets come out in order 0..15 with consecutive timestamps, and `fill_o` reaches 0.
4. **Full with simultaneous push and pop:** with `fill_o`=16, strobe an event while `m_ready_i`=1 → event accepted, `fill_o` stays 16, `drop_cnt_o` unchanged.
5. **Reset mid-operation:** with `fill_o`=7, assert `reset_i` for one cycle together with an event strobe → next cycle `fill_o`=0, `m_valid_o`=0, `ts`=0, and the event is not stored.
6. **Timestamp wrap:** with `TS_WIDTH`=4, strobe events at `ts`=15 and at the following cycle → output timestamps are 15 then 0. Separately, with `CNT_WIDTH`=2, force 5 drops → `drop_cnt_o` saturates at 3.
